// File: rtl/inst_cache_nway_pkg.sv
// Shared types for the N-way instruction cache.
//   DATA_BUS : default fetch/memory bus width
//   state_t  : controller states (ready for fetch, line refill, invalidate-all)
package inst_cache_nway_pkg;

    localparam int DATA_BUS = 32;

    typedef enum logic [1:0] {
        S_READY  = 2'd0,
        S_REFILL = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/inst_cache_nway_if.sv
// Fetch-side and memory-burst-side signals of the instruction cache.
//   slave  : cache view (takes fetch requests and burst data, drives results)
//   master : fetch stage / memory model view
interface inst_cache_nway_if
    import inst_cache_nway_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS
) ();

    logic [DATA_WIDTH-1:0] addr;
    logic                  enable;
    logic                  flush;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_enable;
    logic [DATA_WIDTH-1:0] mem_read;
    logic                  mem_read_valid;
    logic                  mem_last;

    modport slave (
        input  addr, enable, flush, mem_read, mem_read_valid, mem_last,
        output ready, data, data_valid, mem_addr, mem_enable
    );

    modport master (
        output addr, enable, flush, mem_read, mem_read_valid, mem_last,
        input  ready, data, data_valid, mem_addr, mem_enable
    );

endinterface

// File: rtl/inst_cache_nway_lru.sv
// True-LRU age logic for one set (combinational).
//   age_in/valid_in : age vector and valid bits of the selected set
//   touch_way       : way being made most-recently used
//   age_out         : age vector after touching touch_way
//   victim          : lowest invalid way, else the oldest way (age == WAYS-1)
module cache_lru_age #(
    parameter int WAYS_WIDTH = 2,
    localparam int WW = (WAYS_WIDTH > 0) ? WAYS_WIDTH : 1,
    localparam int WAYS = 1 << WAYS_WIDTH
) (
    input  logic [WAYS-1:0][WW-1:0] age_in,
    input  logic [WAYS-1:0]         valid_in,
    input  logic [WW-1:0]           touch_way,
    output logic [WAYS-1:0][WW-1:0] age_out,
    output logic [WW-1:0]           victim
);

    logic          found;
    logic [WW-1:0] touch_age;

    always_comb begin
        age_out   = age_in;
        touch_age = age_in[touch_way];
        // Everything younger than the touched way ages by one; the vector
        // remains a permutation of 0..WAYS-1.
        for (int w = 0; w < WAYS; w++) begin
            if (age_in[w] < touch_age) begin
                age_out[w] = age_in[w] + WW'(1);
            end
        end
        age_out[touch_way] = '0;

        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_in[w] && !found) begin
                victim = WW'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_in[w] == WW'(WAYS - 1)) begin
                    victim = WW'(w);
                end
            end
        end
    end

endmodule

// File: rtl/inst_cache_nway.sv
// N-way set-associative instruction cache with true-LRU replacement,
// early restart on refill, multi-cycle invalidate-all and perf counters.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : fetch request/response and memory burst port (slave view)
//   hit_count   : fetch hits since reset (wraps)
//   miss_count  : fetch misses since reset (wraps)
module inst_cache_nway
    import inst_cache_nway_pkg::*;
#(
    parameter int DATA_WIDTH          = DATA_BUS,
    parameter int DATA_PER_BYTE_WIDTH = 2,
    parameter int WAYS_WIDTH          = 2,
    parameter int INDEX_WIDTH         = 3,
    parameter int OFFSET_WIDTH        = 3,
    parameter int TAG_WIDTH           = DATA_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - DATA_PER_BYTE_WIDTH,
    parameter int CNT_WIDTH           = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inst_cache_nway_if.slave     bus,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int WW    = (WAYS_WIDTH > 0) ? WAYS_WIDTH : 1;
    localparam int WAYS  = 1 << WAYS_WIDTH;
    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int IDX_W = INDEX_WIDTH + WW + OFFSET_WIDTH;
    localparam int DEPTH = 1 << IDX_W;

    typedef logic [WW-1:0]                way_t;
    typedef logic [WAYS-1:0][WW-1:0]      age_vec_t;

    function automatic age_vec_t age_init();
        age_vec_t v;
        for (int w = 0; w < WAYS; w++) begin
            v[w] = WW'(w);
        end
        return v;
    endfunction

    state_t                                    state_q, state_d;
    logic [TAG_WIDTH-1:0]                      tag_r_q, tag_r_d;
    logic [INDEX_WIDTH-1:0]                    index_r_q, index_r_d;
    logic [OFFSET_WIDTH-1:0]                   offset_r_q, offset_r_d;
    way_t                                      victim_q, victim_d;
    logic [OFFSET_WIDTH-1:0]                   wcnt_q, wcnt_d;
    logic                                      early_done_q, early_done_d;
    logic                                      flush_pend_q, flush_pend_d;
    logic [INDEX_WIDTH-1:0]                    flush_set_q, flush_set_d;
    logic [CNT_WIDTH-1:0]                      hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]                      miss_cnt_q, miss_cnt_d;
    logic [SETS-1:0][WAYS-1:0]                 valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0][TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [SETS-1:0][WAYS-1:0][WW-1:0]         age_q, age_d;

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic                  data_we;
    logic [IDX_W-1:0]      data_widx;
    logic [DATA_WIDTH-1:0] data_wdata;

    logic [TAG_WIDTH-1:0]    f_tag;
    logic [INDEX_WIDTH-1:0]  f_index;
    logic [OFFSET_WIDTH-1:0] f_offset;
    logic                    unused_addr_bits;

    logic                    hit;
    way_t                    hit_way;
    logic [INDEX_WIDTH-1:0]  lru_set;
    way_t                    lru_touch_way;
    age_vec_t                lru_age_touched;
    way_t                    lru_victim;

    logic                    ready_o, data_valid_o, mem_enable_o;
    logic [DATA_WIDTH-1:0]   data_o, mem_addr_o;

    assign f_offset         = bus.addr[DATA_PER_BYTE_WIDTH +: OFFSET_WIDTH];
    assign f_index          = bus.addr[DATA_PER_BYTE_WIDTH + OFFSET_WIDTH +: INDEX_WIDTH];
    assign f_tag            = bus.addr[DATA_WIDTH-1 -: TAG_WIDTH];
    assign unused_addr_bits = ^bus.addr[DATA_PER_BYTE_WIDTH-1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[f_index][w] && tag_q[f_index][w] == f_tag) begin
                hit     = 1'b1;
                hit_way = way_t'(w);
            end
        end
    end

    // The single LRU block serves the fetch set while ready and the
    // refilling set while a burst is in flight.
    assign lru_set       = (state_q == S_REFILL) ? index_r_q : f_index;
    assign lru_touch_way = (state_q == S_REFILL) ? victim_q : hit_way;

    cache_lru_age #(.WAYS_WIDTH(WAYS_WIDTH)) u_lru (
        .age_in    (age_q[lru_set]),
        .valid_in  (valid_q[lru_set]),
        .touch_way (lru_touch_way),
        .age_out   (lru_age_touched),
        .victim    (lru_victim)
    );

    always_comb begin
        state_d      = state_q;
        tag_r_d      = tag_r_q;
        index_r_d    = index_r_q;
        offset_r_d   = offset_r_q;
        victim_d     = victim_q;
        wcnt_d       = wcnt_q;
        early_done_d = early_done_q;
        flush_pend_d = flush_pend_q;
        flush_set_d  = flush_set_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        age_d        = age_q;
        data_we      = 1'b0;
        data_widx    = '0;
        data_wdata   = '0;
        ready_o      = 1'b0;
        data_o       = '0;
        data_valid_o = 1'b0;
        mem_enable_o = 1'b0;
        mem_addr_o   = '0;

        case (state_q)
            S_READY: begin
                ready_o = 1'b1;
                if (bus.flush) begin
                    state_d     = S_FLUSH;
                    flush_set_d = '0;
                end else if (bus.enable) begin
                    if (hit) begin
                        data_valid_o     = 1'b1;
                        data_o           = data_mem[{f_index, hit_way, f_offset}];
                        hit_cnt_d        = hit_cnt_q + CNT_WIDTH'(1);
                        age_d[f_index]   = lru_age_touched;
                    end else begin
                        miss_cnt_d   = miss_cnt_q + CNT_WIDTH'(1);
                        tag_r_d      = f_tag;
                        index_r_d    = f_index;
                        offset_r_d   = f_offset;
                        victim_d     = lru_victim;
                        wcnt_d       = '0;
                        early_done_d = 1'b0;
                        state_d      = S_REFILL;
                    end
                end
            end

            S_REFILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag_r_q, index_r_q, {(OFFSET_WIDTH + DATA_PER_BYTE_WIDTH){1'b0}}};
                if (bus.flush) begin
                    flush_pend_d = 1'b1;
                end
                if (bus.mem_read_valid) begin
                    data_we    = 1'b1;
                    data_widx  = {index_r_q, victim_q, wcnt_q};
                    data_wdata = bus.mem_read;
                    wcnt_d     = wcnt_q + OFFSET_WIDTH'(1);
                    // Early restart: forward the requested word as it streams past.
                    if (wcnt_q == offset_r_q && !early_done_q) begin
                        data_valid_o = 1'b1;
                        data_o       = bus.mem_read;
                        early_done_d = 1'b1;
                    end
                    if (bus.mem_last) begin
                        valid_d[index_r_q][victim_q] = 1'b1;
                        tag_d[index_r_q][victim_q]   = tag_r_q;
                        age_d[index_r_q]             = lru_age_touched;
                        if (flush_pend_q || bus.flush) begin
                            state_d      = S_FLUSH;
                            flush_set_d  = '0;
                            flush_pend_d = 1'b0;
                        end else begin
                            state_d = S_READY;
                        end
                    end
                end
            end

            S_FLUSH: begin
                if (bus.flush) begin
                    flush_pend_d = 1'b1;
                end
                valid_d[flush_set_q] = '0;
                age_d[flush_set_q]   = age_init();
                flush_set_d          = flush_set_q + INDEX_WIDTH'(1);
                if (flush_set_q == INDEX_WIDTH'(SETS - 1)) begin
                    // A flush requested while flushing gets a full fresh pass.
                    if (flush_pend_q || bus.flush) begin
                        flush_pend_d = 1'b0;
                    end else begin
                        state_d = S_READY;
                    end
                end
            end

            default: state_d = S_READY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_READY;
            tag_r_q      <= '0;
            index_r_q    <= '0;
            offset_r_q   <= '0;
            victim_q     <= '0;
            wcnt_q       <= '0;
            early_done_q <= 1'b0;
            flush_pend_q <= 1'b0;
            flush_set_q  <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            valid_q      <= '0;
            tag_q        <= '0;
            age_q        <= {SETS{age_init()}};
        end else begin
            state_q      <= state_d;
            tag_r_q      <= tag_r_d;
            index_r_q    <= index_r_d;
            offset_r_q   <= offset_r_d;
            victim_q     <= victim_d;
            wcnt_q       <= wcnt_d;
            early_done_q <= early_done_d;
            flush_pend_q <= flush_pend_d;
            flush_set_q  <= flush_set_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            age_q        <= age_d;
        end
    end

    // Line storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[data_widx] <= data_wdata;
        end
    end

    assign bus.ready      = ready_o;
    assign bus.data       = data_o;
    assign bus.data_valid = data_valid_o;
    assign bus.mem_enable = mem_enable_o;
    assign bus.mem_addr   = mem_addr_o;
    assign hit_count      = hit_cnt_q;
    assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_inst_cache_nway.sv
// Directed bench for inst_cache_nway (default parameters: 4 ways, 8 sets,
// 8 words per line). A reference model keeps per-set valid/tag and a
// last-use timestamp per way; expected outputs for each cycle are set by
// the stimulus tasks from that model and checked on the falling edge.
module tb_inst_cache_nway;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    inst_cache_nway_if #(.DATA_WIDTH(32)) bus_if ();

    inst_cache_nway dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit          chk_en = 1'b0;
    logic        exp_ready, exp_dv, exp_mem_en;
    logic [31:0] exp_data, exp_mem_addr, exp_hits, exp_misses;
    int          dv_seen = 0;

    bit          m_valid [8][4];
    logic [23:0] m_tag   [8][4];
    int          m_stamp [8][4];
    int          m_time;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 32'(bus_if.ready), 32'(exp_ready));
            check("data_valid", 32'(bus_if.data_valid), 32'(exp_dv));
            if (exp_dv) check("data", bus_if.data, exp_data);
            check("mem_enable", 32'(bus_if.mem_enable), 32'(exp_mem_en));
            check("mem_addr", bus_if.mem_addr, exp_mem_addr);
            check("hit_count", hit_count, exp_hits);
            check("miss_count", miss_count, exp_misses);
            if (bus_if.data_valid === 1'b1) dv_seen++;
        end
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a ^ 32'h5A5A_0000) * 32'h0001_0003) + 32'h1234_5678;
    endfunction

    function automatic int m_lookup(input logic [31:0] a);
        int s = int'(a[7:5]);
        for (int w = 0; w < 4; w++)
            if (m_valid[s][w] && m_tag[s][w] == a[31:8]) return w;
        return -1;
    endfunction

    function automatic int m_victim(input int s);
        int best = 0;
        for (int w = 0; w < 4; w++)
            if (!m_valid[s][w]) return w;
        for (int w = 1; w < 4; w++)
            if (m_stamp[s][w] < m_stamp[s][best]) best = w;
        return best;
    endfunction

    task automatic m_touch(input int s, input int w);
        m_time++;
        m_stamp[s][w] = m_time;
    endtask

    task automatic m_clear();
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_stamp[s][w] = -w;
            end
        m_time = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.enable         = 1'b0;
        bus_if.flush          = 1'b0;
        bus_if.mem_read       = 32'h0;
        bus_if.mem_read_valid = 1'b0;
        bus_if.mem_last       = 1'b0;
    endtask

    task automatic exp_idle();
        exp_ready    = 1'b1;
        exp_dv       = 1'b0;
        exp_mem_en   = 1'b0;
        exp_mem_addr = 32'h0;
    endtask

    task automatic flush_cycles();
        for (int c = 0; c < 8; c++) begin
            bus_if.enable = 1'b1;
            bus_if.addr   = 32'h100;
            exp_ready     = 1'b0;
            exp_dv        = 1'b0;
            exp_mem_en    = 1'b0;
            exp_mem_addr  = 32'h0;
            step();
        end
        m_clear();
        idle_inputs();
        exp_idle();
    endtask

    task automatic do_flush(input logic with_enable);
        idle_inputs();
        bus_if.flush  = 1'b1;
        bus_if.enable = with_enable;
        bus_if.addr   = 32'h100;
        exp_idle();
        step();
        bus_if.flush = 1'b0;
        flush_cycles();
    endtask

    // One fetch; on a miss drives the full 8-beat burst. gaps[i] inserts an
    // idle beat (with a stray mem_last) before beat i; flush_beat pulses
    // flush on that beat (-1 for none).
    task automatic fetch(input logic [31:0] a, input logic [7:0] gaps, input int flush_beat);
        int          s    = int'(a[7:5]);
        int          off  = int'(a[4:2]);
        logic [31:0] base = {a[31:5], 5'b0};
        int          way;
        int          vic;
        bit          pend = 1'b0;
        idle_inputs();
        bus_if.addr   = a;
        bus_if.enable = 1'b1;
        exp_idle();
        way = m_lookup(a);
        if (way >= 0) begin
            exp_dv   = 1'b1;
            exp_data = mem_word(a);
            step();
            exp_hits++;
            m_touch(s, way);
        end else begin
            vic = m_victim(s);
            step();
            exp_misses++;
            bus_if.addr  = a ^ 32'h40;
            exp_ready    = 1'b0;
            exp_mem_en   = 1'b1;
            exp_mem_addr = base;
            for (int i = 0; i < 8; i++) begin
                if (gaps[i]) begin
                    bus_if.mem_read_valid = 1'b0;
                    bus_if.mem_last       = 1'b1;
                    bus_if.mem_read       = 32'hBAD0_0000;
                    bus_if.flush          = 1'b0;
                    exp_dv                = 1'b0;
                    step();
                end
                bus_if.mem_read_valid = 1'b1;
                bus_if.mem_read       = mem_word(base + 32'(4 * i));
                bus_if.mem_last       = (i == 7);
                bus_if.flush          = (i == flush_beat);
                if (i == flush_beat) pend = 1'b1;
                exp_dv   = (i == off);
                exp_data = mem_word(base + 32'(4 * i));
                step();
            end
            m_valid[s][vic] = 1'b1;
            m_tag[s][vic]   = a[31:8];
            m_touch(s, vic);
            idle_inputs();
            exp_idle();
            if (pend) flush_cycles();
        end
        idle_inputs();
        exp_idle();
    endtask

    int dv_before;

    initial begin
        rst_n = 1'b0;
        bus_if.addr = 32'h0;
        idle_inputs();
        m_clear();
        exp_hits   = 0;
        exp_misses = 0;
        exp_idle();
        #3;
        check("rst_ready", 32'(bus_if.ready), 32'd1);
        check("rst_data_valid", 32'(bus_if.data_valid), 32'd0);
        check("rst_mem_enable", 32'(bus_if.mem_enable), 32'd0);
        check("rst_mem_addr", bus_if.mem_addr, 32'h0);
        check("rst_data", bus_if.data, 32'h0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_en = 1'b1;
        step();

        // Cold miss with idle beats, stray mem_last and enable held while busy.
        fetch(32'h100, 8'b0010_0100, -1);
        check("cold_miss_count", miss_count, 32'd1);
        fetch(32'h11C, 8'h00, -1);
        check("refetch_hit_count", hit_count, 32'd1);

        // Early restart at offset 5: exactly one data_valid during the burst.
        dv_before = dv_seen;
        fetch(32'h214, 8'b0000_0001, -1);
        check("early_restart_once", 32'(dv_seen - dv_before), 32'd1);
        fetch(32'h7E4, 8'h00, -1);
        fetch(32'h7E0, 8'h00, -1);
        fetch(32'h234, 8'h00, -1);

        // Flush with a same-cycle hit-able fetch: flush wins, nothing counted.
        do_flush(1'b1);
        fetch(32'h100, 8'h00, -1);

        // LRU: fill set 0 with A..D, touch A, E must replace B (way 1).
        fetch(32'h200, 8'h00, -1);
        fetch(32'h300, 8'h00, -1);
        fetch(32'h400, 8'h00, -1);
        fetch(32'h104, 8'h00, -1);
        check("lru_victim_model", 32'(m_victim(0)), 32'd1);
        fetch(32'h50C, 8'h00, -1);
        fetch(32'h308, 8'h00, -1);
        fetch(32'h110, 8'h00, -1);
        fetch(32'h218, 8'h00, -1);
        fetch(32'h41C, 8'h00, -1);

        // Flush pulse mid-refill: burst completes, then the invalidate pass.
        fetch(32'h604, 8'h00, 3);
        fetch(32'h50C, 8'h00, -1);
        fetch(32'h50C, 8'h00, -1);

        // Asynchronous reset in the middle of a burst.
        idle_inputs();
        bus_if.addr   = 32'h900;
        bus_if.enable = 1'b1;
        exp_idle();
        step();
        exp_misses++;
        bus_if.enable = 1'b0;
        exp_ready     = 1'b0;
        exp_mem_en    = 1'b1;
        exp_mem_addr  = 32'h900;
        for (int i = 0; i < 3; i++) begin
            bus_if.mem_read_valid = 1'b1;
            bus_if.mem_read       = mem_word(32'h900 + 32'(4 * i));
            exp_dv                = (i == 0);
            exp_data              = mem_word(32'h900);
            step();
        end
        chk_en = 1'b0;
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus_if.ready), 32'd1);
        check("midrst_mem_enable", 32'(bus_if.mem_enable), 32'd0);
        check("midrst_hit_count", hit_count, 32'd0);
        check("midrst_miss_count", miss_count, 32'd0);
        m_clear();
        exp_hits   = 0;
        exp_misses = 0;
        exp_idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_en = 1'b1;
        fetch(32'h908, 8'h00, -1);
        fetch(32'h900, 8'h00, -1);
        step();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
